// File: rtl/keysw_io.sv
// Memory-mapped push-button / slide-switch input block: 2-flop sync, per-bit debounce,
// sticky press/overrun/change flags with write-1-to-clear, and a combinational read port.
module keysw_io #(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 20
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [DBITS-1:0] DOUT,
    output logic             HIT,
    output logic             IRQ
);
    localparam int NIN = 14;
    // Inputs are handled as one vector: bits [3:0] are keys (idle high), [13:4] switches.
    localparam logic [NIN-1:0]      SYNC_RST = {10'b0, 4'hF};
    localparam logic [CNT_BITS-1:0] DB_LAST  = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] INIT_LEN = CNT_BITS'(DEBOUNCE_CYCLES + 2);
    localparam logic [DBITS-1:0]    A_KDATA  = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0]    A_SDATA  = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0]    A_KSTAT  = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0]    A_SSTAT  = DBITS'(16'hFFF6);

    logic [NIN-1:0]      r_sync1, r_sync2;
    logic [CNT_BITS-1:0] r_init_cnt;
    logic                w_in_init;
    logic [NIN-1:0]      w_acc, w_take;
    logic [3:0]          r_press, r_ovr;
    logic [9:0]          r_chg;
    logic                r_irq;
    logic [3:0]          w_press;
    logic [7:0]          w_kclr;
    logic [9:0]          w_sclr;
    logic                w_unused;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
        end else begin
            r_sync1 <= {SW, KEY};
            r_sync2 <= r_sync1;
        end
    end

    // Power-up window: accepted values track the synced inputs without raising events.
    assign w_in_init = (r_init_cnt != INIT_LEN);

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_init_cnt <= '0;
        else if (w_in_init)
            r_init_cnt <= r_init_cnt + CNT_BITS'(1);
    end

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_db
            logic [CNT_BITS-1:0] r_cnt;
            logic                r_acc;

            assign w_take[gi] = !w_in_init && (r_sync2[gi] != r_acc) && (r_cnt == DB_LAST);
            assign w_acc[gi]  = r_acc;

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_cnt <= '0;
                    r_acc <= SYNC_RST[gi];
                end else if (w_in_init) begin
                    r_cnt <= '0;
                    r_acc <= r_sync2[gi];
                end else if (r_sync2[gi] == r_acc) begin
                    r_cnt <= '0;
                end else if (w_take[gi]) begin
                    r_cnt <= '0;
                    r_acc <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + CNT_BITS'(1);
                end
            end
        end
    endgenerate

    // A key press is an accepted 1->0 transition; OR-ing sets after the clear lets set win.
    assign w_press = w_take[3:0] & w_acc[3:0];
    assign w_kclr  = (WE && ADDR == A_KSTAT) ? DIN[7:0] : 8'h00;
    assign w_sclr  = (WE && ADDR == A_SSTAT) ? DIN[9:0] : 10'h000;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_press <= '0;
            r_ovr   <= '0;
            r_chg   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_press <= (r_press & ~w_kclr[3:0]) | w_press;
            r_ovr   <= (r_ovr & ~w_kclr[7:4]) | (w_press & r_press);
            r_chg   <= (r_chg & ~w_sclr) | w_take[13:4];
            r_irq   <= |{r_ovr, r_press, r_chg};
        end
    end

    assign IRQ = r_irq;

    always_comb begin
        DOUT = '0;
        HIT  = 1'b1;
        case (ADDR)
            A_KDATA: DOUT[3:0] = ~w_acc[3:0];
            A_SDATA: DOUT[9:0] = w_acc[13:4];
            A_KSTAT: DOUT[7:0] = {r_ovr, r_press};
            A_SSTAT: DOUT[9:0] = r_chg;
            default: HIT = 1'b0;
        endcase
    end

    assign w_unused = &{1'b0, DIN};
endmodule
